load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory stage downstream of the single-cycle datapath. Takes the effective address (alu_result) and store data (read_data2) plus decoded load/store controls. Runs a req/ack transaction with a 64-bit data memory and returns the sign- or zero-extended load value on read_data. While the transaction is pending it asserts stall, which freezes the PC and register-file write.

Parameters:
TIMEOUT, 16, cycles to wait for mem_ack before aborting with bus_error (min 2)
TCW, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
memread  input  1  load requested this cycle
memwrite  input  1  store requested this cycle
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
addr  input  64  effective byte address (datapath alu_result)
wdata  input  64  store data, LSB-aligned (datapath read_data2)
read_data  output  64  formatted load result to writeback mux
stall  output  1  hold PC/regfile this cycle
fault  output  1  one-cycle pulse: misaligned, illegal funct3 or memread&memwrite
bus_error  output  1  one-cycle pulse: timeout expired
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = write
mem_addr  output  64  doubleword address, {addr[63:3],3'b0}
mem_wdata  output  64  store data shifted to byte lane addr[2:0]
mem_wstrb  output  8  byte enables for writes, 0 on reads
mem_ack  input  1  memory completes request this cycle
mem_rdata  input  64  read doubleword, valid with mem_ack

Behaviour:
- Reset (reset=0, async): state IDLE; read_data=0, stall=0, fault=0, bus_error=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, timeout counter=0. A reset during BUSY drops mem_req immediately. The pending transaction is discarded.
- op = memread|memwrite. Legality check on IDLE inputs:
  - memread&memwrite is illegal.
  - Stores with funct3[2]=1 are illegal.
  - funct3=111 is illegal.
  - Alignment: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
- stall is combinational: (IDLE & op & legal) | BUSY. It is 0 in DONE and on illegal ops.
- States:
  - IDLE, op & illegal: no memory access; fault=1 next cycle for one cycle; read_data=0; stay IDLE.
  - IDLE, op & legal: on next edge go to BUSY. Register mem_req=1, mem_we=memwrite, mem_addr, mem_wdata=wdata<<(8*addr[2:0]), and mem_wstrb (B 0x01, H 0x03, W 0x0F, D 0xFF, each <<addr[2:0]; 0 for reads). Latch funct3 and addr[2:0]. Clear the counter.
  - BUSY: outputs held stable while mem_ack=0; counter increments each cycle. On mem_ack, the same edge deasserts mem_req and mem_wstrb. For loads, read_data captures mem_rdata>>(8*offset), truncated to size and sign- (B/H/W/D) or zero- (BU/HU/WU) extended to 64 bits. Go to DONE. If the counter reaches TIMEOUT-1 with no ack: drop mem_req, read_data=0, bus_error=1 for one cycle, go to DONE.
  - DONE: stall=0 for exactly one cycle, so the datapath commits using read_data. Unconditionally return to IDLE. Inputs are ignored in DONE.
- read_data holds its value until the next load completes, a fault, or a bus error. Stores do not change it.
- Minimum latency: a legal access with same-cycle ack (ack in the first BUSY cycle) stalls 2 cycles (IDLE, BUSY), then DONE.
- mem_ack outside BUSY is ignored.

Test Plan:
- Reset mid-access: assert reset low in BUSY with mem_req=1 -> mem_req, stall and read_data go 0 asynchronously. After release, state is IDLE and a new load proceeds normally.
- LB sign: addr=0x1005, funct3=000, mem_rdata=0x0000_8000_0000_0000 (byte 5=0x80), ack on first BUSY cycle -> mem_addr=0x1000, mem_wstrb=0. read_data=0xFFFF_FFFF_FFFF_FF80 in DONE. stall high for exactly 2 cycles.
- LWU/LW: addr=0x2004, mem_rdata=0x8765_4321_xxxx_xxxx. funct3=110 -> read_data=0x0000_0000_8765_4321. funct3=010 -> read_data=0xFFFF_FFFF_8765_4321.
- SH: addr=0x3006, wdata=0xABCD, ack after 3 BUSY cycles -> mem_we=1, mem_wstrb=0xC0, mem_wdata[63:48]=0xABCD. Outputs stable across wait cycles. read_data unchanged.
- Fault: LD at addr=0x4004, then memread=memwrite=1 -> no mem_req, fault pulses one cycle each, stall stays 0, read_data=0.
- Timeout: LD addr=0x5000, mem_ack never asserted, TIMEOUT=16 -> mem_req high for exactly 16 cycles, then bus_error pulses one cycle, read_data=0, stall drops in DONE.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory stage behind the single-cycle datapath. Validates a load/store
//   request, runs one req/ack transaction against a 64-bit data memory and
//   returns the size-formatted, sign/zero-extended load value. The datapath
//   is stalled from the request cycle until the transaction resolves.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   memread    load requested this cycle
//   memwrite   store requested this cycle
//   funct3     size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
//   addr       effective byte address
//   wdata      store data, LSB-aligned
//   read_data  formatted load result (held until next load/fault/bus error)
//   stall      hold PC and register-file write
//   fault      one-cycle pulse on misaligned / illegal request
//   bus_error  one-cycle pulse when the memory does not answer in time
//   mem_req    memory request, held until mem_ack
//   mem_we     1 = write
//   mem_addr   doubleword-aligned address
//   mem_wdata  store data placed on its byte lanes
//   mem_wstrb  byte enables for writes, 0 on reads
//   mem_ack    memory completes the request this cycle
//   mem_rdata  read doubleword, valid with mem_ack
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int TCW     = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  funct3,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] read_data,
  output logic        stall,
  output logic        fault,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_next;
  logic [TCW-1:0]  count, count_next;
  logic [2:0]      op_f3, op_f3_next;
  logic [2:0]      op_off, op_off_next;

  logic [63:0]     read_data_next, mem_addr_next, mem_wdata_next;
  logic [7:0]      mem_wstrb_next;
  logic            fault_next, bus_error_next, mem_req_next, mem_we_next;

  logic            op, misaligned, legal;
  logic [7:0]      size_strb;
  logic [63:0]     shifted, load_value;

  assign op = memread | memwrite;

  // funct3[1:0] encodes the access size for both signed and unsigned loads.
  always_comb begin
    misaligned = 1'b0;
    size_strb  = 8'h01;
    case (funct3[1:0])
      2'b01: begin misaligned = addr[0];       size_strb = 8'h03; end
      2'b10: begin misaligned = |addr[1:0];    size_strb = 8'h0F; end
      2'b11: begin misaligned = |addr[2:0];    size_strb = 8'hFF; end
      default: begin misaligned = 1'b0;        size_strb = 8'h01; end
    endcase
  end

  assign legal = !(memread & memwrite) && !(memwrite & funct3[2]) &&
                 (funct3 != 3'b111) && !misaligned;

  assign stall = ((state == IDLE) && op && legal) || (state == BUSY);

  // Bring the addressed byte lane down to bit 0, then truncate and extend.
  assign shifted = mem_rdata >> {op_off, 3'b000};

  always_comb begin
    load_value = 64'd0;
    case (op_f3)
      3'b000:  load_value = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  load_value = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  load_value = {{32{shifted[31]}}, shifted[31:0]};
      3'b011:  load_value = shifted;
      3'b100:  load_value = {56'd0, shifted[7:0]};
      3'b101:  load_value = {48'd0, shifted[15:0]};
      3'b110:  load_value = {32'd0, shifted[31:0]};
      default: load_value = 64'd0;
    endcase
  end

  always_comb begin
    state_next     = state;
    count_next     = count;
    op_f3_next     = op_f3;
    op_off_next    = op_off;
    read_data_next = read_data;
    mem_req_next   = mem_req;
    mem_we_next    = mem_we;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    mem_wstrb_next = mem_wstrb;
    fault_next     = 1'b0;
    bus_error_next = 1'b0;

    case (state)
      IDLE: begin
        if (op) begin
          if (!legal) begin
            fault_next     = 1'b1;
            read_data_next = 64'd0;
          end else begin
            state_next     = BUSY;
            count_next     = '0;
            op_f3_next     = funct3;
            op_off_next    = addr[2:0];
            mem_req_next   = 1'b1;
            mem_we_next    = memwrite;
            mem_addr_next  = {addr[63:3], 3'b000};
            mem_wdata_next = wdata << {addr[2:0], 3'b000};
            mem_wstrb_next = memwrite ? (size_strb << addr[2:0]) : 8'h00;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          // An ack always wins over a timeout in the same cycle.
          mem_req_next   = 1'b0;
          mem_wstrb_next = 8'h00;
          if (!mem_we)
            read_data_next = load_value;
          state_next = DONE;
        end else if (count == TCW'(TIMEOUT - 1)) begin
          mem_req_next   = 1'b0;
          mem_wstrb_next = 8'h00;
          read_data_next = 64'd0;
          bus_error_next = 1'b1;
          state_next     = DONE;
        end else begin
          count_next = count + TCW'(1);
        end
      end
      DONE: begin
        // Commit cycle for the datapath; requests are not sampled here.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      op_f3     <= 3'd0;
      op_off    <= 3'd0;
      read_data <= 64'd0;
      fault     <= 1'b0;
      bus_error <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 64'd0;
      mem_wdata <= 64'd0;
      mem_wstrb <= 8'h00;
    end else begin
      state     <= state_next;
      count     <= count_next;
      op_f3     <= op_f3_next;
      op_off    <= op_off_next;
      read_data <= read_data_next;
      fault     <= fault_next;
      bus_error <= bus_error_next;
      mem_req   <= mem_req_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      mem_wstrb <= mem_wstrb_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed and randomized checks of load_store_unit against a byte-level
//   reference model (legality, lane placement, load extension, timeout).
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] addr = 64'd0;
  logic [63:0] wdata = 64'd0;
  logic [63:0] read_data;
  logic        stall, fault, bus_error, mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_rd = 64'd0;

  load_store_unit #(.TIMEOUT(TIMEOUT), .TCW(5)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .funct3(funct3), .addr(addr), .wdata(wdata), .read_data(read_data),
    .stall(stall), .fault(fault), .bus_error(bus_error), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic bit legal_m(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [63:0] a);
    if (rd && wr) return 1'b0;
    if (f3 == 3'd7) return 1'b0;
    if (wr && int'(f3) >= 4) return 1'b0;
    return (int'(a[2:0]) % size_of(f3)) == 0;
  endfunction

  function automatic logic [63:0] load_m(input logic [2:0] f3, input logic [63:0] a,
                                         input logic [63:0] rdata);
    int sz = size_of(f3);
    int o  = int'(a[2:0]);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = rdata[8*(o+i) +: 8];
    if (int'(f3) < 4 && v[8*sz-1])
      for (int i = 8*sz; i < 64; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] wstrb_m(input logic [2:0] f3, input logic [63:0] a);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < size_of(f3); i++) s[int'(a[2:0]) + i] = 1'b1;
    return s;
  endfunction

  // One complete access from the IDLE request cycle back to IDLE.
  // delay = index of the BUSY cycle carrying mem_ack (>= TIMEOUT: never).
  task automatic do_access(input string name, input bit rd, input bit wr,
                           input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, input int delay,
                           input logic [63:0] rdata);
    bit lg;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_strb;
    lg = legal_m(rd, wr, f3, a);
    memread = rd; memwrite = wr; funct3 = f3; addr = a; wdata = wd;
    #1;
    check({name, ".idle_stall"}, stall, 64'(lg));
    @(posedge clk); #1;
    // Inputs change while stalled; the unit must use its latched copy.
    memread = 1'b0; memwrite = 1'b0; funct3 = 3'($urandom);
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    if (!lg) begin
      exp_rd = 64'd0;
      check({name, ".fault"}, fault, 64'd1);
      check({name, ".fault_req"}, mem_req, 64'd0);
      check({name, ".fault_stall"}, stall, 64'd0);
      check({name, ".fault_rd"}, read_data, exp_rd);
      @(posedge clk); #1;
      check({name, ".fault_pulse"}, fault, 64'd0);
      $display("[TB] %s rd=%0d wr=%0d f3=%0d addr=%h -> fault", name, rd, wr, f3, a);
      return;
    end
    e_addr  = a & ~64'h7;
    e_wdata = wd << (8 * int'(a[2:0]));
    e_strb  = wr ? wstrb_m(f3, a) : 8'h00;
    for (int k = 0; k < TIMEOUT; k++) begin
      check({name, ".busy_stall"}, stall, 64'd1);
      check({name, ".busy_req"}, mem_req, 64'd1);
      check({name, ".busy_we"}, mem_we, 64'(wr));
      check({name, ".busy_addr"}, mem_addr, e_addr);
      check({name, ".busy_wdata"}, mem_wdata, e_wdata);
      check({name, ".busy_wstrb"}, mem_wstrb, 64'(e_strb));
      if (k == delay) mem_ack = 1'b1;
      mem_rdata = (k == delay) ? rdata : {$urandom, $urandom};
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (k == delay) begin
        if (rd) exp_rd = load_m(f3, a, rdata);
        check({name, ".done_stall"}, stall, 64'd0);
        check({name, ".done_req"}, mem_req, 64'd0);
        check({name, ".done_wstrb"}, mem_wstrb, 64'd0);
        check({name, ".done_berr"}, bus_error, 64'd0);
        check({name, ".done_rd"}, read_data, exp_rd);
        break;
      end
      if (k == TIMEOUT - 1) begin
        exp_rd = 64'd0;
        check({name, ".to_berr"}, bus_error, 64'd1);
        check({name, ".to_req"}, mem_req, 64'd0);
        check({name, ".to_stall"}, stall, 64'd0);
        check({name, ".to_rd"}, read_data, exp_rd);
      end
    end
    @(posedge clk); #1;
    check({name, ".idle_berr"}, bus_error, 64'd0);
    check({name, ".idle_fault"}, fault, 64'd0);
    check({name, ".idle_req"}, mem_req, 64'd0);
    $display("[TB] %s rd=%0d wr=%0d f3=%0d addr=%h delay=%0d read_data=%h", name, rd, wr, f3,
             a, delay, read_data);
  endtask

  logic [63:0] r_addr;
  logic [2:0]  r_f3;
  int          r_kind, r_delay;

  initial begin
    // Reset values
    #2;
    check("rst_rd", read_data, 64'd0);
    check("rst_stall", stall, 64'd0);
    check("rst_req", mem_req, 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    check("rst_wstrb", mem_wstrb, 64'd0);
    check("rst_fault", fault, 64'd0);
    check("rst_berr", bus_error, 64'd0);
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;

    do_access("lb_sign", 1, 0, 3'b000, 64'h1005, 64'd0, 0, 64'h0000_8000_0000_0000);
    check("lb_const", read_data, 64'hFFFF_FFFF_FFFF_FF80);
    do_access("lwu", 1, 0, 3'b110, 64'h2004, 64'd0, 1, 64'h8765_4321_1234_5678);
    check("lwu_const", read_data, 64'h0000_0000_8765_4321);
    do_access("lw", 1, 0, 3'b010, 64'h2004, 64'd0, 2, 64'h8765_4321_1234_5678);
    check("lw_const", read_data, 64'hFFFF_FFFF_8765_4321);
    do_access("sh", 0, 1, 3'b001, 64'h3006, 64'hABCD, 3, 64'd0);
    check("sh_rd_kept", read_data, 64'hFFFF_FFFF_8765_4321);
    do_access("ld_mis", 1, 0, 3'b011, 64'h4004, 64'd0, 0, 64'd0);
    do_access("rdwr", 1, 1, 3'b000, 64'h4000, 64'd0, 0, 64'd0);
    do_access("ld_ok", 1, 0, 3'b011, 64'h4008, 64'd0, 0, 64'h0123_4567_89AB_CDEF);
    do_access("timeout", 1, 0, 3'b011, 64'h5000, 64'd0, 99, 64'd0);
    do_access("ack_last", 1, 0, 3'b101, 64'h5002, 64'd0, TIMEOUT - 1, 64'h0000_0000_9876_0000);

    // mem_ack outside BUSY must be ignored
    mem_ack = 1'b1; mem_rdata = '1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("stray_ack_rd", read_data, exp_rd);
    check("stray_ack_req", mem_req, 64'd0);
    $display("[TB] stray ack in IDLE read_data=%h", read_data);

    // Reset in the middle of a pending load
    do_access("pre_rst", 1, 0, 3'b000, 64'h6001, 64'd0, 0, 64'h0000_0000_0000_F000);
    memread = 1'b1; funct3 = 3'b011; addr = 64'h6000;
    @(posedge clk); #1;
    memread = 1'b0;
    check("mid_req", mem_req, 64'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    exp_rd = 64'd0;
    check("arst_req", mem_req, 64'd0);
    check("arst_stall", stall, 64'd0);
    check("arst_rd", read_data, exp_rd);
    $display("[TB] async reset during BUSY");
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_stall", stall, 64'd0);
    do_access("post_rst_ld", 1, 0, 3'b100, 64'h7003, 64'd0, 1, 64'h0000_0000_AB00_0000);

    // Randomized accesses
    for (int n = 0; n < 40; n++) begin
      r_kind = $urandom_range(0, 9);
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0)
        r_addr = r_addr & ~64'(size_of(r_f3) - 1);
      r_delay = ($urandom_range(0, 4) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 3);
      do_access("rand", (r_kind <= 5), (r_kind == 0) || (r_kind >= 6), r_f3, r_addr,
                {$urandom, $urandom}, r_delay, {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
